// File: rtl/lfsr_pkg.sv
// Shared constants, tap table and FSM state type for the LFSR stream decryptor.
package lfsr_pkg;

  localparam int MSG_LEN   = 64;
  localparam int TRAIN_LEN = 10;
  localparam int NUM_TAPS  = 9;

  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [6:0] TAP [0:NUM_TAPS-1] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    STRIP,
    RUN,
    PAD,
    DONE
  } state_t;

  // Lowest set bit of a candidate mask; 0 when the mask is empty.
  function automatic logic [3:0] first_candidate(input logic [NUM_TAPS-1:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int p = NUM_TAPS - 1; p >= 0; p--) begin
      if (mask[p]) idx = 4'(p);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One step of the 7-bit Fibonacci LFSR: shift left, feedback = parity of tapped bits.
module lfsr_step (
  input  logic [6:0] state_in,
  input  logic [6:0] tap,
  output logic [6:0] state_out
);

  assign state_out = {state_in[5:0], ^(state_in & tap)};

endmodule

// File: rtl/lfsr_decrypt_stream.sv
// Trains on a space preamble to recover the LFSR tap/seed, then decrypts a 64-byte stream.
// Optional feature: define PARITY_FLAG_EN to report per-byte parity errors and abort on bad training bytes.
module lfsr_decrypt_stream
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       req,
  output logic       ack,
  output logic       err,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] ptrn_idx,
  output logic [6:0] lfsr_seed
);

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          ptrn_idx_q, ptrn_idx_d;
  logic [6:0]          lfsr_seed_q, lfsr_seed_d;
  logic [6:0]          lfsr_q, lfsr_d;
  logic [5:0]          in_cnt_q, in_cnt_d;
  logic [6:0]          out_cnt_q, out_cnt_d;
  logic [NUM_TAPS-1:0] mask_q, mask_d;

  logic [6:0]          cand_next [0:NUM_TAPS-1];
  logic [6:0]          lfsr_cur;
  logic [6:0]          obs;
  logic [6:0]          plain;
  logic                perr;
  logic                accept;
  logic                out_free;
  logic                last_in;
  logic                is_space;
  logic [NUM_TAPS-1:0] mask_upd;

  // lfsr_q is the keystream state of the last consumed byte, so each instance
  // predicts the state of the byte now on in_data under its own tap.
  for (genvar p = 0; p < NUM_TAPS; p++) begin : g_step
    lfsr_step u_step (
      .state_in  (lfsr_q),
      .tap       (TAP[p]),
      .state_out (cand_next[p])
    );
  end

  always_comb begin
    lfsr_cur = cand_next[0];
    for (int p = 1; p < NUM_TAPS; p++) begin
      if (ptrn_idx_q == 4'(p)) lfsr_cur = cand_next[p];
    end
  end

`ifdef PARITY_FLAG_EN
  assign perr = ^in_data;
`else
  logic unused_parity_bit;
  assign perr              = 1'b0;
  assign unused_parity_bit = in_data[7];
`endif

  assign obs      = in_data[6:0] ^ SPACE[6:0];
  assign plain    = in_data[6:0] ^ lfsr_cur;
  assign is_space = !perr && (plain == SPACE[6:0]);
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = ((state_q == TRAIN) || (state_q == STRIP) || (state_q == RUN)) && out_free;
  assign accept   = in_valid && in_ready;
  assign last_in  = (in_cnt_q == 6'(MSG_LEN - 1));

  always_comb begin
    for (int p = 0; p < NUM_TAPS; p++) begin
      mask_upd[p] = mask_q[p] && (cand_next[p] == obs);
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    ptrn_idx_d  = ptrn_idx_q;
    lfsr_seed_d = lfsr_seed_q;
    lfsr_d      = lfsr_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    mask_d      = mask_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = TRAIN;
          ack_d      = 1'b0;
          err_d      = 1'b0;
          in_cnt_d   = 6'd0;
          out_cnt_d  = 7'd0;
          mask_d     = '1;
          ptrn_idx_d = 4'd0;
        end
      end

      TRAIN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 6'd1;
          lfsr_d   = obs;
          if (in_cnt_q == 6'd0) begin
            lfsr_seed_d = obs;
          end else begin
            mask_d = mask_upd;
          end
          if (perr) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (in_cnt_q == 6'(TRAIN_LEN - 1)) begin
            if (mask_upd == '0) begin
              state_d = DONE;
              ack_d   = 1'b1;
              err_d   = 1'b1;
            end else begin
              ptrn_idx_d = first_candidate(mask_upd);
              state_d    = STRIP;
            end
          end
        end
      end

      // Leading spaces after the preamble are dropped; the first real byte opens RUN.
      STRIP: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 6'd1;
          lfsr_d   = lfsr_cur;
          if (!is_space) begin
            out_data_d  = {perr, plain};
            out_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + 7'd1;
            state_d     = RUN;
          end
          if (last_in) state_d = PAD;
        end
      end

      RUN: begin
        if (accept) begin
          in_cnt_d    = in_cnt_q + 6'd1;
          lfsr_d      = lfsr_cur;
          out_data_d  = {perr, plain};
          out_valid_d = 1'b1;
          out_cnt_d   = out_cnt_q + 7'd1;
          if (last_in) state_d = PAD;
        end
      end

      PAD: begin
        if (out_free) begin
          out_data_d  = SPACE;
          out_valid_d = 1'b1;
          out_cnt_d   = out_cnt_q + 7'd1;
          if (out_cnt_q == 7'(MSG_LEN - 1)) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b0;
          end
        end
      end

      // Wait for the last byte to drain; ack stays high in IDLE until the next req.
      DONE: begin
        if (!out_valid_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ptrn_idx_q  <= 4'd0;
      lfsr_seed_q <= 7'd0;
      lfsr_q      <= 7'd0;
      in_cnt_q    <= 6'd0;
      out_cnt_q   <= 7'd0;
      mask_q      <= '1;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ptrn_idx_q  <= ptrn_idx_d;
      lfsr_seed_q <= lfsr_seed_d;
      lfsr_q      <= lfsr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      mask_q      <= mask_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ptrn_idx  = ptrn_idx_q;
  assign lfsr_seed = lfsr_seed_q;

endmodule

// File: tb/tb_lfsr_decrypt_stream.sv
// Directed bench for lfsr_decrypt_stream: encrypts known messages, streams them in, checks the decrypted output.
module tb_lfsr_decrypt_stream;

  logic       clk;
  logic       init_n;
  logic       req;
  logic       ack;
  logic       err;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ptrn_idx;
  logic [6:0] lfsr_seed;

  int vec_count   = 0;
  int miscompares = 0;

  logic [7:0] cipher_q [64];
  logic [7:0] expect_q [64];
  logic [7:0] got_q    [64];
  string      msg = "four score and seven years ago our fathers brought forth";

  lfsr_decrypt_stream dut (
    .clk       (clk),
    .init_n    (init_n),
    .req       (req),
    .ack       (ack),
    .err       (err),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptrn_idx  (ptrn_idx),
    .lfsr_seed (lfsr_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] tbStep(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ack"},       32'(ack),       32'h0);
    checkOutput({tag, "_err"},       32'(err),       32'h0);
    checkOutput({tag, "_in_ready"},  32'(in_ready),  32'h0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, "_out_data"},  32'(out_data),  32'h0);
    checkOutput({tag, "_ptrn_idx"},  32'(ptrn_idx),  32'h0);
    checkOutput({tag, "_lfsr_seed"}, 32'(lfsr_seed), 32'h0);
  endtask

  // Encrypts a 64-byte plaintext (10 training spaces + pre extra spaces + msg),
  // streams it through the DUT and compares every output byte against the plaintext.
  task automatic applyStimulus(
    input string      name,
    input logic [6:0] tap,
    input logic [6:0] seed,
    input logic [3:0] exp_idx,
    input int         pre,
    input int         cor_idx,
    input logic [7:0] cor_mask,
    input int         stall_at,
    input int         reset_at
  );
    logic [6:0] s;
    logic [6:0] c7;
    logic [7:0] plain_b [64];
    logic [7:0] held;
    int         first_out, sent, recv, stall_left, exp_n;
    bit         done, stall_started, held_v, in_fire, out_fire, exp_abort;

    first_out = 10 + pre;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      if (i < first_out) plain_b[i] = 8'h20;
      else               plain_b[i] = msg.getc(i - first_out);
      c7 = plain_b[i][6:0] ^ s;
      cipher_q[i] = {^c7, c7};
      if (i == cor_idx) cipher_q[i] = cipher_q[i] ^ cor_mask;
      s = tbStep(s, tap);
    end
    for (int j = 0; j < 64; j++) begin
      if (j < 64 - first_out) begin
        expect_q[j] = {1'b0, plain_b[first_out + j][6:0]};
        if (first_out + j == cor_idx) begin
          expect_q[j][6:0] = expect_q[j][6:0] ^ cor_mask[6:0];
`ifdef PARITY_FLAG_EN
          expect_q[j][7] = ^cipher_q[cor_idx];
`endif
        end
      end else begin
        expect_q[j] = 8'h20;
      end
      got_q[j] = 8'h00;
    end

    exp_abort = 1'b0;
`ifdef PARITY_FLAG_EN
    exp_abort = (cor_idx >= 0) && (cor_idx < 10) && (^cor_mask);
`endif
    exp_n = exp_abort ? 0 : 64;

    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checkOutput({name, "_ack_cleared"}, 32'(ack), 32'h0);
    checkOutput({name, "_err_cleared"}, 32'(err), 32'h0);

    sent = 0; recv = 0; stall_left = 0;
    done = 1'b0; stall_started = 1'b0; held_v = 1'b0; held = 8'h00;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid = (sent < 64);
      in_data  = cipher_q[(sent < 64) ? sent : 63];
      if (stall_at >= 0 && recv == stall_at && !stall_started) begin
        stall_left    = 5;
        stall_started = 1'b1;
      end
      out_ready = (stall_left == 0);
      req       = (cyc == 15) && !ack;
      #2;
      if (stall_left > 0) begin
        if (out_valid) begin
          checkOutput({name, "_stall_in_ready"}, 32'(in_ready), 32'h0);
          if (!held_v) begin
            held   = out_data;
            held_v = 1'b1;
          end else begin
            checkOutput({name, "_stall_hold"}, 32'(out_data), 32'(held));
          end
        end
        stall_left--;
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (recv < 64) begin
          checkOutput($sformatf("%s_out%0d", name, recv), 32'(out_data), 32'(expect_q[recv]));
          got_q[recv] = out_data;
        end
        recv++;
      end
      if (in_fire) sent++;
      if (reset_at >= 0 && recv == reset_at) begin
        init_n   = 1'b0;
        in_valid = 1'b0;
        req      = 1'b0;
        #1;
        checkReset({name, "_midrun"});
        done = 1'b1;
      end else if (ack && !out_valid) begin
        done = 1'b1;
      end
    end
    in_valid  = 1'b0;
    req       = 1'b0;
    out_ready = 1'b1;

    checkOutput({name, "_finished"}, 32'(done), 32'h1);
    if (reset_at >= 0) begin
      @(negedge clk);
      init_n = 1'b1;
      return;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_count"},     32'(recv),      32'(exp_n));
    checkOutput({name, "_ack"},       32'(ack),       32'h1);
    checkOutput({name, "_err"},       32'(err),       32'(exp_abort));
    checkOutput({name, "_seed"},      32'(lfsr_seed), 32'(seed));
    checkOutput({name, "_idle_rdy"},  32'(in_ready),  32'h0);
    if (!exp_abort) checkOutput({name, "_ptrn"}, 32'(ptrn_idx), 32'(exp_idx));
  endtask

  initial begin
    init_n    = 1'b0;
    req       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #1;
    checkReset("por");
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);

    applyStimulus("s1", 7'h60, 7'h01, 4'd0, 4, -1, 8'h00, -1, -1);
    checkOutput("s1_byte0",  32'(got_q[0]),  32'h66);
    checkOutput("s1_byte1",  32'(got_q[1]),  32'h6F);
    checkOutput("s1_byte2",  32'(got_q[2]),  32'h75);
    checkOutput("s1_byte3",  32'(got_q[3]),  32'h72);
    checkOutput("s1_byte63", 32'(got_q[63]), 32'h20);

    applyStimulus("s2", 7'h7B, 7'h55, 4'd8, 26, -1, 8'h00, -1, -1);
    checkOutput("s2_byte0", 32'(got_q[0]), 32'h66);

    // Byte 40 carries plaintext 'g' (msg index 28); bit 2 flipped gives 0x63.
    applyStimulus("s3", 7'h60, 7'h3A, 4'd0, 2, 40, 8'h04, 5, -1);
`ifdef PARITY_FLAG_EN
    checkOutput("s3_flagged", 32'(got_q[28]), 32'hE3);
`else
    checkOutput("s3_flagged", 32'(got_q[28]), 32'h63);
`endif
    checkOutput("s3_before", 32'(got_q[27]), 32'h61);
    checkOutput("s3_after",  32'(got_q[29]), 32'h6F);

    applyStimulus("s4", 7'h60, 7'h11, 4'd0, 0, 3, 8'h80, -1, -1);

    applyStimulus("s5", 7'h60, 7'h22, 4'd0, 3, -1, 8'h00, -1, 10);
    checkReset("s5_released");

    applyStimulus("s6", 7'h60, 7'h47, 4'd0, 5, -1, 8'h00, -1, -1);
    checkOutput("s6_byte0", 32'(got_q[0]), 32'h66);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
